// File: rtl/cic_decim_buffer.sv
// Output buffer for the CIC decimator. It recovers the decimation strobe, discards warm-up
// samples and queues the captured samples for a valid/ready consumer.
// Optional build macro CIC_DROP_COUNT_EN adds a saturating drop counter port.
module cic_decim_buffer #(
    parameter int unsigned LENGTH = 5,
    parameter int unsigned SIZE   = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SKIP   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE-1:0]              y_in,
    output logic [SIZE-1:0]              m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
`ifdef CIC_DROP_COUNT_EN
    ,
    output logic [7:0]                   drop_count
`endif
);

    localparam int unsigned PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [PW-1:0]   phase_q, phase_d;
    logic [3:0]      skip_q, skip_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [SIZE-1:0] mem_q [DEPTH];

    logic cap, skip_done, full, empty;
    logic push_req, push, pop, drop;

    // Strobe tracks the filter's own counter, which shares clock and reset.
    assign cap       = (phase_q == PW'(LENGTH - 1));
    assign skip_done = (skip_q == 4'd0);
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);

    assign pop      = !empty && m_ready;
    assign push_req = cap && skip_done;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        phase_d    = cap ? '0 : phase_q + 1'b1;
        skip_d     = (cap && !skip_done) ? skip_q - 4'd1 : skip_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | drop;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q    <= '0;
            skip_q     <= 4'(SKIP);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            skip_q     <= skip_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: its contents are only visible behind m_valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= y_in;
        end
    end

    assign m_valid  = !empty;
    assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;

`ifdef CIC_DROP_COUNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: doc/cic_decim_buffer.md
# cic_decim_buffer

Downstream stage of the CIC / moving-average filter. The filter asserts a decimated sample on `y_out` once every `LENGTH` clocks and drives 0 otherwise. This block regenerates the decimation phase, captures only the valid samples, and discards the warm-up outputs. It buffers the captured samples in a small FIFO and delivers them to the consumer over a valid/ready handshake, reporting overflow.

## Interface
Parameters:
- `LENGTH`, 5, decimation ratio; must match the filter's `LENGTH` (≥2)
- `SIZE`, 8, sample width; must match the filter's `SIZE`
- `DEPTH`, 4, FIFO entries, power of two, ≥2
- `SKIP`, 1, number of initial decimated samples discarded after reset (filter warm-up), 0..15

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clock `clock`
- `y_in`  in  SIZE  connected to filter `y_out`
- `m_data`  out  SIZE  head-of-FIFO sample
- `m_valid`  out  1  `m_data` holds a valid sample
- `m_ready`  in  1  consumer accepts the sample on this edge
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy
- `overflow`  out  1  sticky; a captured sample was dropped because the FIFO was full
- `drop_count`  out  8  only with `CIC_DROP_COUNT_EN` (see Configuration)

## Operation
- Phase counter `phase`, width $clog2(LENGTH). It resets to 0, increments every clock, and wraps from LENGTH-1 to 0. It runs in lockstep with the filter's internal counter because both blocks share `clock` and `reset`.
- Strobe `cap = (phase == LENGTH-1)`. `y_in` is sampled only on `cap` cycles; on all other cycles it is ignored, including when it is non-zero.
- Skip counter: starts at `SKIP` after reset and decrements on each `cap`. While it is non-zero, captured samples are discarded and nothing is written to the FIFO.
- Push: `cap` and skip done. If the FIFO is not full, `y_in` is written at the tail.
- FIFO full on push, no pop on the same edge: the new sample is dropped, the FIFO contents are unchanged, and `overflow` is set.
- FIFO full on push, with a pop on the same edge: both the push and the pop happen, `level` is unchanged, and there is no overflow.
- Pop: `m_valid && m_ready` advances the head.
- `m_ready` while `m_valid = 0` has no effect.
- `level` is 0..DEPTH. Read and write pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are decided from `level`.
- `m_data` = head entry when `m_valid = 1`, otherwise 0.
- Data is passed unmodified: no scaling, truncation or sign handling.

## Timing
- Reset values: `phase=0`, skip counter=`SKIP`, `level=0`, `m_valid=0`, `m_data=0`, `overflow=0`, `drop_count=0`.
- The first `cap` is at the LENGTH-th rising edge after reset deassertion, i.e. `phase` 0..LENGTH-1 spans edges 1..LENGTH.
- Push-to-output latency: a sample pushed into an empty FIFO on edge N appears with `m_valid=1` in the cycle after edge N. The FIFO output is registered; there is no combinational path from `y_in` to `m_data`.
- `m_valid` is combinational from `level != 0`. `m_data` is read from the registered head.
- `m_valid` stays high, with `m_data` stable, until it is accepted.
- Throughput: at most 1 push per LENGTH cycles. A consumer holding `m_ready=1` never sees overflow.
- `overflow` clears only on reset.
- Reset mid-operation, asynchronous: the FIFO empties, `m_valid` drops immediately, and `phase` and the skip count restart.

## Configuration
- Macro: `CIC_DROP_COUNT_EN`.
- Defined: the `drop_count` port exists. It is an 8-bit counter of dropped samples that increments on each overflow drop, saturates at 255, and resets to 0.
- Undefined: the `drop_count` port and its logic are absent. `overflow` behaves identically in both builds.

## Test plan
- Capture alignment: LENGTH=5, SKIP=1, `y_in` = edge index (1,2,3,…), `m_ready=1`. Edge 5 is skipped. The outputs are 10, then 15, then 20, one per 5 cycles, each visible one cycle after capture.
- Non-strobe rejection: `y_in=0xAA` except on `cap` edges, where `y_in=0x33`. Every output equals 0x33.
- Fill/overflow: DEPTH=4, SKIP=0, `m_ready=0`, `y_in=1,2,3,4,5` on five strobes. Result: `level=4`, `overflow=1`, `drop_count=1`. Then `m_ready=1` drains 1,2,3,4 on consecutive cycles, and `level` returns to 0.
- Simultaneous push/pop at full: FIFO holds 1..4, `m_ready=1` on a `cap` edge with `y_in=9`. Result: `level` stays 4, `overflow=0`, and the drain order is 2,3,4,9.
- Backpressure hold: `m_ready` toggles 0/1 every cycle. `m_data` is stable while `m_valid && !m_ready`, and no sample is lost or duplicated.
- Reset mid-stream: assert `reset` with `level=3`. `m_valid=0` and `m_data=0` immediately. After release, the first capture is again at edge LENGTH and is skipped per `SKIP`.
